sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 30 +++
 rtl/sram_rr_arb.sv | 49 ++++
 rtl/sram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared widths, map bounds and FSM state type for the sprite/display SRAM arbiter.
// Coordinates pack into a 20-bit word address with x in the low half.
package SramPkg;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int COORD_W = 10;

  // One extra bit so the x bound (the full 10-bit range) is not a constant comparison.
  localparam logic [COORD_W:0] MAP_X = 11'd1023;
  localparam logic [COORD_W:0] MAP_Y = 11'd767;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

  function automatic logic coord_oob(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return ({1'b0, x} > MAP_X) || ({1'b0, y} > MAP_Y);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin selector for the write ports: one-hot grant starting the search at
// the pointer; the pointer moves past the granted port only when i_en is high.
module sram_rr_arb
  import SramPkg::*;
#(
  parameter int N_WR = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_WR-1:0] i_req,
  input  logic            i_en,
  output logic [N_WR-1:0] o_grant
);

  logic [1:0] r_ptr;
  int         w_gidx;
  int         w_next_ptr;

  // Descending offsets so the port closest to the pointer is assigned last and wins.
  always_comb begin
    o_grant = '0;
    w_gidx  = 0;
    for (int k = N_WR - 1; k >= 0; k--) begin
      for (int p = 0; p < N_WR; p++) begin
        if (i_req[p] && (((int'(r_ptr) + k) % N_WR) == p)) begin
          o_grant    = '0;
          o_grant[p] = 1'b1;
          w_gidx     = p;
        end
      end
    end
  end

  always_comb begin
    w_next_ptr = 0;
    if (w_gidx != N_WR - 1) begin
      w_next_ptr = w_gidx + 1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 2'd0;
    end else if (i_en && (|i_req)) begin
      r_ptr <= 2'(w_next_ptr);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter: display read port with absolute priority over
// N_WR round-robin sprite write ports, registered SRAM pins, write-to-read turnaround.
module sram_arbiter
  import SramPkg::*;
#(
  parameter int N_WR = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_rd_req,
  input  logic [COORD_W-1:0]             i_rd_x,
  input  logic [COORD_W-1:0]             i_rd_y,
  output logic                           o_rd_ack,
  output logic                           o_rd_valid,
  output logic [DATA_W-1:0]              o_rd_data,
  input  logic [N_WR-1:0]                i_wr_req,
  input  logic [N_WR-1:0][COORD_W-1:0]   i_wr_x,
  input  logic [N_WR-1:0][COORD_W-1:0]   i_wr_y,
  input  logic [N_WR-1:0][DATA_W-1:0]    i_wr_data,
  output logic [N_WR-1:0]                o_wr_ack,
  output logic                           o_oob,
  output logic [ADDR_W-1:0]              o_sram_addr,
  output logic [DATA_W-1:0]              o_sram_dq_out,
  output logic                           o_sram_dq_oe,
  output logic                           o_sram_we_n,
  output logic                           o_sram_oe_n,
  output logic                           o_sram_ce_n,
  output logic                           o_sram_lb_n,
  output logic                           o_sram_ub_n,
  input  logic [DATA_W-1:0]              i_sram_dq_in
);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_oob;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_sram_dq_out;
  logic                r_sram_dq_oe;
  logic                r_sram_we_n;
  logic                r_sram_oe_n;
  logic                r_sram_ce_n;

  logic                w_rd_take;
  logic                w_wr_take;
  logic                w_oob;
  logic [N_WR-1:0]     w_grant;
  logic [COORD_W-1:0]  w_sel_x;
  logic [COORD_W-1:0]  w_sel_y;
  logic [DATA_W-1:0]   w_sel_data;
  logic [COORD_W-1:0]  w_x;
  logic [COORD_W-1:0]  w_y;

  sram_rr_arb #(
    .N_WR (N_WR)
  ) u_rr_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_wr_req),
    .i_en    (w_wr_take),
    .o_grant (w_grant)
  );

  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_data = '0;
    for (int p = 0; p < N_WR; p++) begin
      if (w_grant[p]) begin
        w_sel_x    = i_wr_x[p];
        w_sel_y    = i_wr_y[p];
        w_sel_data = i_wr_data[p];
      end
    end
  end

  // A read right after a WRITE cycle is held off so the bus can turn around.
  assign w_rd_take = !i_rst && i_rd_req && (r_state != ST_TURN) && (r_state != ST_WRITE);
  assign w_wr_take = !i_rst && !i_rd_req && (|i_wr_req) && (r_state != ST_TURN);

  assign w_x   = w_rd_take ? i_rd_x : w_sel_x;
  assign w_y   = w_rd_take ? i_rd_y : w_sel_y;
  assign w_oob = coord_oob(w_x, w_y);

  assign o_rd_ack = w_rd_take;
  assign o_wr_ack = w_wr_take ? w_grant : '0;

  always_comb begin
    w_state_next = ST_IDLE;
    if (w_rd_take && !w_oob) begin
      w_state_next = ST_READ;
    end else if (w_wr_take && !w_oob) begin
      w_state_next = ST_WRITE;
    end else if ((r_state == ST_WRITE) && i_rd_req && !i_rst) begin
      w_state_next = ST_TURN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_oob         <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
      r_sram_ce_n   <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= (r_state == ST_READ);
      if (r_state == ST_READ) begin
        r_rd_data <= i_sram_dq_in;
      end
      r_oob <= (w_rd_take || w_wr_take) && w_oob;
      // Address holds its last value whenever no access is launched.
      if ((w_state_next == ST_READ) || (w_state_next == ST_WRITE)) begin
        r_sram_addr <= pack_addr(w_x, w_y);
      end
      if (w_state_next == ST_WRITE) begin
        r_sram_dq_out <= w_sel_data;
      end
      r_sram_dq_oe <= (w_state_next == ST_WRITE);
      r_sram_we_n  <= (w_state_next != ST_WRITE);
      r_sram_oe_n  <= (w_state_next != ST_READ);
      r_sram_ce_n  <= !((w_state_next == ST_READ) || (w_state_next == ST_WRITE));
    end
  end

  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_oob         = r_oob;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_oe  = r_sram_dq_oe;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_sram_oe_n   = r_sram_oe_n;
  assign o_sram_ce_n   = r_sram_ce_n;
  assign o_sram_lb_n   = r_sram_ce_n;
  assign o_sram_ub_n   = r_sram_ce_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM; unwritten words read as addr[15:0]^A5A5.
module tb_sram_arbiter;

  logic              clk;
  logic              rst;
  logic              rd_req;
  logic [9:0]        rd_x;
  logic [9:0]        rd_y;
  logic              rd_ack;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic [1:0]        wr_req;
  logic [1:0][9:0]   wr_x;
  logic [1:0][9:0]   wr_y;
  logic [1:0][15:0]  wr_data;
  logic [1:0]        wr_ack;
  logic              oob;
  logic [19:0]       sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ce_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  logic [15:0]       sram_dq_in;

  logic [15:0] mem [logic [19:0]];

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.N_WR(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rd_req      (rd_req),
    .i_rd_x        (rd_x),
    .i_rd_y        (rd_y),
    .o_rd_ack      (rd_ack),
    .o_rd_valid    (rd_valid),
    .o_rd_data     (rd_data),
    .i_wr_req      (wr_req),
    .i_wr_x        (wr_x),
    .i_wr_y        (wr_y),
    .i_wr_data     (wr_data),
    .o_wr_ack      (wr_ack),
    .o_oob         (oob),
    .o_sram_addr   (sram_addr),
    .o_sram_dq_out (sram_dq_out),
    .o_sram_dq_oe  (sram_dq_oe),
    .o_sram_we_n   (sram_we_n),
    .o_sram_oe_n   (sram_oe_n),
    .o_sram_ce_n   (sram_ce_n),
    .o_sram_lb_n   (sram_lb_n),
    .o_sram_ub_n   (sram_ub_n),
    .i_sram_dq_in  (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM pins are stable for the whole cycle, so the model acts mid-cycle.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dq_out;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_in = mem.exists(sram_addr) ? mem[sram_addr] : (sram_addr[15:0] ^ 16'hA5A5);
    else
      sram_dq_in = 16'h0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k0;
    int k1;
    logic [1:0] exp_ack;
    rst = 1'b1; rd_req = 1'b1; rd_x = '0; rd_y = '0;
    wr_req = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    sram_dq_in = '0;
    repeat (2) cyc();
    #1;
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_pins", 32'({sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n}), 32'b011111);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_oob", 32'(oob), 0);
    $display("reset: pins idle, acks gated");

    // Single read at (5,3)
    cyc(); rst = 1'b0; rd_req = 1'b1; rd_x = 10'd5; rd_y = 10'd3; #1;
    chk("rd1_ack", 32'(rd_ack), 1);
    chk("rd1_wr_ack", 32'(wr_ack), 0);
    cyc(); rd_req = 1'b0; #1;
    chk("rd1_addr", 32'(sram_addr), 32'h00C05);
    chk("rd1_pins", 32'({sram_oe_n, sram_ce_n, sram_we_n, sram_dq_oe}), 32'b0010);
    chk("rd1_early_valid", 32'(rd_valid), 0);
    cyc(); #1;
    chk("rd1_valid", 32'(rd_valid), 1);
    chk("rd1_data", 32'(rd_data), 32'hA9A0);
    cyc(); #1;
    chk("rd1_valid_drop", 32'(rd_valid), 0);
    $display("read (5,3): data %h", 16'hA9A0);

    // Read and write 0 together: read first, write acked during the READ cycle
    cyc(); rd_req = 1'b1; rd_x = 10'd1; rd_y = 10'd1;
    wr_req = 2'b01; wr_x[0] = 10'd10; wr_y[0] = 10'd2; wr_data[0] = 16'hBEEF; #1;
    chk("pri_rd_ack", 32'(rd_ack), 1);
    chk("pri_wr_ack", 32'(wr_ack), 0);
    cyc(); rd_req = 1'b0; #1;
    chk("pri_wr_ack2", 32'(wr_ack), 32'b01);
    chk("pri_oe_n", 32'(sram_oe_n), 0);
    cyc(); wr_req = 2'b00; #1;
    chk("pri_wr_pins", 32'({sram_we_n, sram_dq_oe}), 32'b01);
    chk("pri_wr_addr", 32'(sram_addr), 32'h0080A);
    chk("pri_wr_dq", 32'(sram_dq_out), 32'hBEEF);
    chk("pri_rd_valid", 32'(rd_valid), 1);
    chk("pri_rd_data", 32'(rd_data), 32'hA1A4);
    cyc(); #1;
    chk("pri_idle_pins", 32'({sram_we_n, sram_dq_oe}), 32'b10);
    chk("pri_mem", 32'(mem.exists(20'h0080A) ? mem[20'h0080A] : 16'h0000), 32'hBEEF);
    $display("read+write: read first, write next cycle");

    // Round-robin with both ports writing continuously
    rst = 1'b1; cyc(); rst = 1'b0;
    k0 = 0; k1 = 0;
    for (int i = 0; i < 4; i++) begin
      wr_req = 2'b11;
      wr_x[0] = 10'(20 + k0); wr_y[0] = 10'd4; wr_data[0] = 16'(16'h1000 + k0);
      wr_x[1] = 10'(40 + k1); wr_y[1] = 10'd4; wr_data[1] = 16'(16'h2000 + k1);
      #1;
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_ack", 32'(wr_ack), 32'(exp_ack));
      if (i > 0) chk("rr_we_n", 32'(sram_we_n), 0);
      $display("rr step %0d: ack %b", i, wr_ack);
      if (exp_ack[0]) k0++; else k1++;
      cyc();
    end

    // Read request during the last WRITE cycle forces a TURN
    wr_req = 2'b00; rd_req = 1'b1; rd_x = 10'd20; rd_y = 10'd4; #1;
    chk("turn_wcyc_ack", 32'(rd_ack), 0);
    chk("turn_wcyc_we_n", 32'(sram_we_n), 0);
    cyc(); #1;
    chk("turn_ack", 32'(rd_ack), 0);
    chk("turn_pins", 32'({sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n}), 32'b0111);
    cyc(); #1;
    chk("turn_rd_ack", 32'(rd_ack), 1);
    cyc(); rd_x = 10'd41; #1;
    chk("b2b_ack", 32'(rd_ack), 1);
    chk("b2b_addr0", 32'(sram_addr), 32'h01014);
    chk("b2b_oe_n", 32'(sram_oe_n), 0);
    cyc(); rd_req = 1'b0; #1;
    chk("b2b_valid0", 32'(rd_valid), 1);
    chk("b2b_data0", 32'(rd_data), 32'h1000);
    chk("b2b_addr1", 32'(sram_addr), 32'h01029);
    cyc(); #1;
    chk("b2b_valid1", 32'(rd_valid), 1);
    chk("b2b_data1", 32'(rd_data), 32'h2001);
    cyc(); #1;
    chk("b2b_valid_end", 32'(rd_valid), 0);
    $display("turnaround + back-to-back readback done");

    // Out-of-range write at (100,768)
    cyc(); wr_req = 2'b01; wr_x[0] = 10'd100; wr_y[0] = 10'd768; wr_data[0] = 16'hDEAD; #1;
    chk("oob_ack", 32'(wr_ack), 32'b01);
    cyc(); wr_req = 2'b00; #1;
    chk("oob_pulse", 32'(oob), 1);
    chk("oob_we_n", 32'(sram_we_n), 1);
    chk("oob_ce_n", 32'(sram_ce_n), 1);
    cyc(); #1;
    chk("oob_drop", 32'(oob), 0);
    chk("oob_mem", 32'(mem.exists(20'hC0064)), 0);
    $display("oob write: acked, no access");

    // Reset right after a read ack aborts the read
    cyc(); rd_req = 1'b1; rd_x = 10'd7; rd_y = 10'd7; #1;
    chk("abort_ack", 32'(rd_ack), 1);
    cyc(); rd_req = 1'b0; rst = 1'b1; #1;
    chk("abort_oe_n", 32'(sram_oe_n), 0);
    cyc(); #1;
    chk("abort_valid", 32'(rd_valid), 0);
    chk("abort_addr", 32'(sram_addr), 0);
    chk("abort_pins", 32'({sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n}), 32'b011111);
    chk("abort_data", 32'(rd_data), 0);
    cyc(); rst = 1'b0; #1;
    chk("abort_valid2", 32'(rd_valid), 0);
    $display("reset abort: read dropped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
